// File: rtl/ps2_key_decoder_if.sv
`default_nettype none
// ============================================================================
//  ps2_key_decoder_if
//  Raw PS/2 pins in, decoded key vectors and debug strobes out.
//  Revision: 1.0
// ============================================================================
interface ps2_key_decoder_if;
    logic       PS2_CLK;
    logic       PS2_DATA;
    logic [3:0] wasd;
    logic [3:0] arrows;
    logic [7:0] code;
    logic       code_valid;
    logic       frame_err;

    // Board/stimulus side: drives the pins, observes the decoder.
    modport master (
        output PS2_CLK,
        output PS2_DATA,
        input  wasd,
        input  arrows,
        input  code,
        input  code_valid,
        input  frame_err
    );

    // Decoder side.
    modport slave (
        input  PS2_CLK,
        input  PS2_DATA,
        output wasd,
        output arrows,
        output code,
        output code_valid,
        output frame_err
    );
endinterface
`default_nettype wire

// File: rtl/ps2_key_decoder.sv
`default_nettype none
// ============================================================================
//  ps2_key_decoder
//  PS/2 set-2 receiver producing held WASD / arrow key vectors.
//  Revision: 1.0
// ============================================================================
module ps2_key_decoder #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  wire logic         CLOCK,
    input  wire logic         RESETN,
    ps2_key_decoder_if.slave  bus
);

    localparam int c_IDLE_W = ($clog2(TIMEOUT_CYCLES + 1) > 16) ? $clog2(TIMEOUT_CYCLES + 1) : 16;
    localparam logic [c_IDLE_W-1:0] c_TIMEOUT = c_IDLE_W'(TIMEOUT_CYCLES);

    localparam logic [7:0] c_EXT_PREFIX = 8'hE0;
    localparam logic [7:0] c_BRK_PREFIX = 8'hF0;
    localparam logic [7:0] c_BAT_PASS   = 8'hAA;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXT    = 2'd1,
        ST_BRK    = 2'd2,
        ST_EXTBRK = 2'd3
    } state_t;

    logic [1:0]          r_clkSync;
    logic [1:0]          r_dataSync;
    logic                r_clkPrev;
    logic                r_fallEdge;
    logic                r_dataBit;
    logic [3:0]          r_bitCnt;
    logic [8:0]          r_frame;
    logic [c_IDLE_W-1:0] r_idleCnt;
    state_t              r_state;
    logic [3:0]          w_wasdHit;
    logic [3:0]          w_arrowHit;

    // Frame receiver: the edge strobe and its data bit are registered together
    // so the sampled bit is the one present when the clock fell.
    always_ff @(posedge CLOCK) begin
        if (!RESETN) begin
            r_clkSync      <= 2'b11;
            r_dataSync     <= 2'b11;
            r_clkPrev      <= 1'b1;
            r_fallEdge     <= 1'b0;
            r_dataBit      <= 1'b1;
            r_bitCnt       <= 4'd0;
            r_frame        <= 9'd0;
            r_idleCnt      <= '0;
            bus.code       <= 8'h00;
            bus.code_valid <= 1'b0;
            bus.frame_err  <= 1'b0;
        end else begin
            r_clkSync      <= {r_clkSync[0], bus.PS2_CLK};
            r_dataSync     <= {r_dataSync[0], bus.PS2_DATA};
            r_clkPrev      <= r_clkSync[1];
            r_fallEdge     <= r_clkPrev & ~r_clkSync[1];
            r_dataBit      <= r_dataSync[1];
            bus.code_valid <= 1'b0;
            bus.frame_err  <= 1'b0;

            if (r_fallEdge) begin
                r_idleCnt <= '0;
                case (r_bitCnt)
                    4'd0: begin
                        if (!r_dataBit) begin
                            r_bitCnt <= 4'd1;
                        end
                    end
                    4'd10: begin
                        r_bitCnt <= 4'd0;
                        if ((^r_frame) && r_dataBit) begin
                            bus.code       <= r_frame[7:0];
                            bus.code_valid <= 1'b1;
                        end else begin
                            bus.frame_err  <= 1'b1;
                        end
                    end
                    default: begin
                        r_frame  <= {r_dataBit, r_frame[8:1]};
                        r_bitCnt <= r_bitCnt + 4'd1;
                    end
                endcase
            end else if (r_bitCnt != 4'd0) begin
                if (r_idleCnt == c_TIMEOUT) begin
                    r_bitCnt      <= 4'd0;
                    r_idleCnt     <= '0;
                    bus.frame_err <= 1'b1;
                end else begin
                    r_idleCnt <= r_idleCnt + 1'b1;
                end
            end else begin
                r_idleCnt <= '0;
            end
        end
    end

    always_comb begin
        w_wasdHit  = 4'b0000;
        w_arrowHit = 4'b0000;
        case (bus.code)
            8'h1D:   w_wasdHit  = 4'b0001;
            8'h1C:   w_wasdHit  = 4'b0010;
            8'h1B:   w_wasdHit  = 4'b0100;
            8'h23:   w_wasdHit  = 4'b1000;
            8'h75:   w_arrowHit = 4'b0001;
            8'h6B:   w_arrowHit = 4'b0010;
            8'h72:   w_arrowHit = 4'b0100;
            8'h74:   w_arrowHit = 4'b1000;
            default: ;
        endcase
    end

    // Prefix FSM: one byte per code_valid; key vectors follow one cycle later.
    always_ff @(posedge CLOCK) begin
        if (!RESETN) begin
            r_state    <= ST_IDLE;
            bus.wasd   <= 4'b0000;
            bus.arrows <= 4'b0000;
        end else if (bus.frame_err) begin
            r_state <= ST_IDLE;
        end else if (bus.code_valid) begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.code == c_EXT_PREFIX) begin
                        r_state <= ST_EXT;
                    end else if (bus.code == c_BRK_PREFIX) begin
                        r_state <= ST_BRK;
                    end else if (bus.code == c_BAT_PASS) begin
                        bus.wasd   <= 4'b0000;
                        bus.arrows <= 4'b0000;
                    end else begin
                        bus.wasd <= bus.wasd | w_wasdHit;
                    end
                end
                ST_EXT: begin
                    if (bus.code == c_BRK_PREFIX) begin
                        r_state <= ST_EXTBRK;
                    end else if (bus.code != c_EXT_PREFIX) begin
                        bus.arrows <= bus.arrows | w_arrowHit;
                        r_state    <= ST_IDLE;
                    end
                end
                ST_BRK: begin
                    bus.wasd <= bus.wasd & ~w_wasdHit;
                    r_state  <= ST_IDLE;
                end
                ST_EXTBRK: begin
                    bus.arrows <= bus.arrows & ~w_arrowHit;
                    r_state    <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
